muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath; executes mult, multu, div, divu.
- Sits in parallel with the ALU and directly downstream of the register file read ports: consumes rs/rt operands and holds results in architectural HI/LO registers.
- The writeback mux reads HI/LO for mfhi/mflo; the controller stalls the pipeline on busy.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative 32-step multiply/divide unit with architectural HI/LO.
// Rev     : 1.0  initial release
// ============================================================================

module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int            C_CW   = $clog2(ITER);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;

    logic [C_CW-1:0] r_count;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;
    logic [31:0]     r_a_orig;
    logic [31:0]     r_divisor;
    logic [63:0]     r_acc;

    logic            w_signed;
    logic [31:0]     w_abs_a;
    logic [31:0]     w_abs_b;
    logic [32:0]     w_sum;
    logic [63:0]     w_mul_nx;
    logic [32:0]     w_diff;
    logic            w_fits;
    logic [63:0]     w_div_nx;
    logic [63:0]     w_prod;
    logic [31:0]     w_quo;
    logic [31:0]     w_rmd;
    logic [31:0]     w_hi_res;
    logic [31:0]     w_lo_res;

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b  = (w_signed && b[31]) ? (32'd0 - b) : b;

    // Multiply: r_acc[31:0] holds the multiplier, partial product grows in the upper half.
    assign w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_divisor};
    assign w_mul_nx = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Divide: r_acc[63:32] is the remainder, r_acc[31:0] shifts dividend out / quotient in.
    // The remainder stays below max(divisor, 2^32) so bit 32 of the difference is its sign.
    assign w_diff   = r_acc[63:31] - {1'b0, r_divisor};
    assign w_fits   = ~w_diff[32];
    assign w_div_nx = w_fits ? {w_diff[31:0], r_acc[30:0], 1'b1}
                             : {r_acc[62:0], 1'b0};

    assign w_prod   = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quo    = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rmd    = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_hi_res = r_is_div ? (r_div_zero ? r_a_orig : w_rmd) : w_prod[63:32];
    assign w_lo_res = r_is_div ? (r_div_zero ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_CALC;
            S_CALC:  if (r_count == C_LAST) w_state_nx = S_FIX;
            S_FIX:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_orig   <= 32'd0;
            r_divisor  <= 32'd0;
            r_acc      <= 64'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count    <= '0;
                        r_is_div   <= op[1];
                        r_neg_q    <= w_signed & (a[31] ^ b[31]);
                        r_neg_r    <= w_signed & a[31];
                        r_div_zero <= op[1] & (b == 32'd0);
                        r_a_orig   <= a;
                        r_divisor  <= w_abs_b;
                        r_acc      <= {32'd0, w_abs_a};
                    end else begin
                        if (mthi) hi <= wd;
                        if (mtlo) lo <= wd;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + 1'b1;
                    r_acc   <= r_is_div ? w_div_nx : w_mul_nx;
                end
                S_FIX: begin
                    hi   <= w_hi_res;
                    lo   <= w_lo_res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit (vector table + scoreboard).
// Rev     : 1.0  initial release
// ============================================================================

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    muldiv_unit #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wd    (wd),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb_q[$];
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    // Called one cycle after the start edge (plus n0 extra cycles already spent).
    task automatic wait_result(input string name, input int n0, input int inject_at);
        int          n;
        int          early_done;
        logic [63:0] exp;
        n          = n0;
        early_done = 0;
        while (busy && n < 100) begin
            if (done) early_done++;
            if (n == inject_at) begin
                start = 1'b1;
                op    = C_DIVU;
                a     = 32'd100;
                b     = 32'd7;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_busy_cycles"}, 64'(n), 64'd33);
        chk({name, "_no_early_done"}, 64'(early_done), 64'd0);
        chk({name, "_done_pulse"}, 64'(done), 64'd1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk({name, "_hi_lo"}, {hi, lo}, exp);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", name);
        end
        @(negedge clk);
        chk({name, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{C_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{C_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{C_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
        vecs[4]  = '{C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{C_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{C_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{C_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{C_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{C_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[10] = '{C_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
        vecs[11] = '{C_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wd    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_result($sformatf("vec%0d", i), 0, -1);
        end

        // A second start 10 cycles into a running op must be ignored.
        issue(C_MULT, 32'd6, 32'd7, 32'd0, 32'd42);
        wait_result("start_while_busy", 0, 10);
        @(negedge clk);
        chk("start_while_busy_idle", 64'(busy), 64'd0);

        @(negedge clk);
        mthi = 1'b1; wd = 32'hAAAA_0000;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wd = 32'h0000_5555;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});
        mthi = 1'b1; mtlo = 1'b1; wd = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

        start = 1'b1; op = C_MULTU; a = 32'd3; b = 32'd5;
        mtlo  = 1'b1; wd = 32'h0000_DEAD;
        sb_q.push_back({32'd0, 32'd15});
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start_beats_mtlo", 64'(lo), 64'h1234_5678);
        mthi = 1'b1; wd = 32'h0000_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_while_busy", 64'(hi), 64'h1234_5678);
        wait_result("mt_seq", 1, -1);

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wd = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; op = C_DIVU; a = 32'h0FFF_FFFF; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_hi_lo", {hi, lo}, 64'd0);
        chk("async_reset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {31'd0, busy, hi, lo}, 64'd0);
        issue(C_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
        wait_result("after_reset", 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
